// File: rtl/multi_timer.sv
// Bank of NUM_CH down-counting timers behind a word-addressed register port.
// Each channel runs IDLE/LOAD/CNT/INT and raises a maskable pending interrupt on expiry.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ_vec,
  output logic              IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  logic [1:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic [3:0]       ctrl_rd    [NUM_CH];
  logic [CNT_W-1:0] preset_rd  [NUM_CH];
  logic [CNT_W-1:0] count_rd   [NUM_CH];
  logic [NUM_CH-1:0] pending_rd;
  logic             unused_bits;

  assign ch_sel      = Addr[5:4];
  assign reg_sel     = Addr[3:2];
  assign unused_bits = ^{Addr[31:6], Din};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             pending;
    logic             sel;

    // Channel numbers at or above NUM_CH never match, so those writes are dropped.
    assign sel = WE && (ch_sel == 2'(k));

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= IDLE;
        ctrl    <= '0;
        preset  <= '0;
        count   <= '0;
        pending <= 1'b0;
      end else if (sel) begin
        // A write to this channel freezes its FSM for the cycle.
        case (reg_sel)
          2'd0:    ctrl   <= Din[3:0];
          2'd1:    preset <= Din[CNT_W-1:0];
          2'd2:    count  <= Din[CNT_W-1:0];
          default: if (Din[0]) pending <= 1'b0;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (ctrl[0]) begin
              state   <= LOAD;
              pending <= 1'b0;
            end
          end
          LOAD: begin
            count <= preset;
            state <= CNT;
          end
          CNT: begin
            if (!ctrl[0]) begin
              state <= IDLE;
            end else if (count > CNT_W'(1)) begin
              count <= count - CNT_W'(1);
            end else begin
              count   <= '0;
              pending <= 1'b1;
              state   <= INT;
            end
          end
          INT: begin
            // Mode 00 is one-shot; every other mode reloads.
            if (ctrl[2:1] == 2'b00) begin
              ctrl[0] <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign ctrl_rd[k]    = ctrl;
    assign preset_rd[k]  = preset;
    assign count_rd[k]   = count;
    assign pending_rd[k] = pending;
    assign IRQ_vec[k]    = pending & ctrl[3];
  end

  always_comb begin
    Dout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == 2'(k)) begin
        case (reg_sel)
          2'd0:    Dout = {28'd0, ctrl_rd[k]};
          2'd1:    Dout = 32'(preset_rd[k]);
          2'd2:    Dout = 32'(count_rd[k]);
          default: Dout = {31'd0, pending_rd[k]};
        endcase
      end
    end
  end

  assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: register reads are scoreboarded through exp_q,
// interrupt outputs are sampled mid-cycle alongside them.
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:2] addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [1:0]  irq_vec;
  logic        irq;

  logic [31:2] a8 = '0;
  logic        we8 = 1'b0;
  logic [31:0] din8 = '0;
  logic [31:0] dout8;
  logic [0:0]  irq_vec8;
  logic        irq8;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  multi_timer #(.NUM_CH(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(addr), .WE(we), .Din(din),
    .Dout(dout), .IRQ_vec(irq_vec), .IRQ(irq)
  );

  multi_timer #(.NUM_CH(1), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .Addr(a8), .WE(we8), .Din(din8),
    .Dout(dout8), .IRQ_vec(irq_vec8), .IRQ(irq8)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle at the falling edge, return just after the rising edge.
  task automatic cyc(input logic we_i, input int ch, input int rg, input logic [31:0] din_i,
                     input bit rd_chk, input logic [31:0] rd_exp, input int irq_exp,
                     input int vec_exp, input string tag);
    logic [31:0] e;
    addr = '0;
    addr[5:4] = 2'(ch);
    addr[3:2] = 2'(rg);
    we = we_i;
    din = din_i;
    if (rd_chk) exp_q.push_back(rd_exp);
    @(negedge clk);
    if (rd_chk) begin
      e = exp_q.pop_front();
      check_val(tag, dout, e);
    end
    if (irq_exp >= 0) check_val({tag, "_irq"}, {31'd0, irq}, 32'(irq_exp));
    if (vec_exp >= 0) check_val({tag, "_vec"}, {30'd0, irq_vec}, 32'(vec_exp));
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    cyc(1'b1, ch, rg, d, 1'b0, '0, -1, -1, "wr");
  endtask

  task automatic rd(input string tag, input int ch, input int rg, input logic [31:0] e);
    cyc(1'b0, ch, rg, '0, 1'b1, e, -1, -1, tag);
  endtask

  task automatic rdi(input string tag, input int ch, input int rg, input logic [31:0] e,
                     input int irq_e, input int vec_e);
    cyc(1'b0, ch, rg, '0, 1'b1, e, irq_e, vec_e, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 0, 0, '0, 1'b0, '0, -1, -1, "rst");
    reset = 1'b0;
  endtask

  initial begin
    int e0;
    int e1;
    logic [31:0] e;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    rdi("rst_ctrl0", 0, 0, 0, 0, 0);
    rd("rst_preset0", 0, 1, 0);
    rd("rst_count0", 0, 2, 0);
    rd("rst_status0", 0, 3, 0);
    rd("rst_ctrl1", 1, 0, 0);

    // One-shot: preset 5, IM=1
    wr(0, 1, 5);
    wr(0, 0, 32'h9);
    rd("os_idle", 0, 2, 0);
    rd("os_load", 0, 2, 0);
    for (int v = 5; v >= 2; v--) rd("os_cnt", 0, 2, 32'(v));
    rdi("os_cnt1", 0, 2, 1, 0, -1);
    rdi("os_int", 0, 2, 0, 1, 1);
    rdi("os_en_clr", 0, 0, 32'h8, 1, -1);
    rd("os_status", 0, 3, 1);
    wr(0, 3, 32'h2);
    rdi("os_w0_noclr", 0, 3, 1, 1, -1);
    wr(0, 3, 32'h1);
    rdi("os_w1_clr", 0, 3, 0, 0, 0);

    // Auto-reload on ch1: preset 3, IM=1
    do_reset();
    wr(1, 1, 3);
    wr(1, 0, 32'hB);
    rd("ar_idle", 1, 2, 0);
    rd("ar_load", 1, 2, 0);
    rd("ar_c3", 1, 2, 3);
    rd("ar_c2", 1, 2, 2);
    rdi("ar_c1", 1, 2, 1, 0, -1);
    rdi("ar_int", 1, 2, 0, 1, 2);
    rdi("ar_load2", 1, 2, 0, 1, -1);
    rdi("ar_reload", 1, 2, 3, 1, -1);
    rd("ar_r2", 1, 2, 2);
    rd("ar_r1", 1, 2, 1);
    rd("ar_int2", 1, 2, 0);
    rd("ar_load3", 1, 2, 0);
    rd("ar_r3b", 1, 2, 3);
    wr(1, 3, 32'h1);
    rdi("ar_clr_stall", 1, 2, 2, 0, -1);
    rd("ar_after_clr", 1, 2, 1);
    rdi("ar_reset_pend", 1, 2, 0, 1, -1);

    // Stall isolation: ch0 counts from 100 while ch1 gets written
    do_reset();
    wr(0, 1, 100);
    wr(0, 0, 32'h1);
    wr(1, 1, 50);
    wr(1, 0, 32'h1);
    rd("st_ch0_a", 0, 2, 100);
    rd("st_ch0_b", 0, 2, 99);
    e0 = 98;
    e1 = 50;
    for (int i = 0; i < 5; i++) begin
      rd("st_ch1", 1, 2, 32'(e1));
      e0--; e1--;
      wr(1, 1, 50);
      e0--;
      rd("st_ch0", 0, 2, 32'(e0));
      e0--; e1--;
    end

    // Masked expiry, then unmask
    do_reset();
    wr(0, 1, 2);
    wr(0, 0, 32'h1);
    rd("mk_idle", 0, 3, 0);
    rd("mk_load", 0, 3, 0);
    rd("mk_c2", 0, 2, 2);
    rdi("mk_c1", 0, 2, 1, 0, -1);
    rdi("mk_pend", 0, 3, 1, 0, 0);
    wr(0, 0, 32'h9);
    rdi("mk_unmask", 0, 3, 1, 1, 1);
    rdi("mk_reload_clr", 0, 3, 0, 0, 0);

    // Out-of-range channel and reset mid-count
    do_reset();
    wr(1, 0, 32'hB);
    wr(3, 0, 32'h5);
    rd("oor_rd", 3, 0, 0);
    rd("oor_no_alias", 1, 0, 32'hB);
    wr(0, 1, 32'h50);
    wr(0, 0, 32'h1);
    rd("rm_ch1_pend_a", 1, 3, 1);
    rd("rm_ch1_pend_b", 1, 3, 1);
    for (int v = 32'h50; v > 32'h40; v--) rd("rm_cnt", 0, 2, 32'(v));
    reset = 1'b1;
    rdi("rm_at_40", 0, 2, 32'h40, 1, 2);
    reset = 1'b0;
    rdi("rm_ctrl0", 0, 0, 0, 0, 0);
    rd("rm_preset0", 0, 1, 0);
    rd("rm_count0", 0, 2, 0);
    rd("rm_status0", 0, 3, 0);
    rd("rm_ctrl1", 1, 0, 0);
    rd("rm_status1", 1, 3, 0);
    rd("rm_oor_preset", 3, 1, 0);

    // Preset 0: INT two cycles after LOAD
    do_reset();
    wr(0, 0, 32'h9);
    rdi("p0_idle", 0, 2, 0, 0, -1);
    rdi("p0_load", 0, 2, 0, 0, -1);
    rdi("p0_cnt", 0, 2, 0, 0, -1);
    rdi("p0_int", 0, 2, 0, 1, 1);
    rd("p0_en_clr", 0, 0, 32'h8);

    // Register masking
    wr(1, 0, 32'hFFFF_FFF6);
    rd("ctrl_mask", 1, 0, 32'h6);
    wr(1, 2, 32'h1234);
    rd("count_wr", 1, 2, 32'h1234);

    // Narrow counter instance
    a8 = '0;
    a8[3:2] = 2'd1;
    we8 = 1'b1;
    din8 = 32'h1FF;
    @(posedge clk);
    #1;
    we8 = 1'b0;
    exp_q.push_back(32'hFF);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("w8_preset", dout8, e);
    a8[3:2] = 2'd2;
    we8 = 1'b1;
    din8 = 32'h3AB;
    @(posedge clk);
    #1;
    we8 = 1'b0;
    exp_q.push_back(32'hAB);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("w8_count", dout8, e);
    check_val("w8_irq", {31'd0, irq8}, 32'd0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
